// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the unified-memory access unit.
// Imported by mem_lane_align and mem_access_unit.
package mem_pkg;

   localparam logic [1:0] OP_FETCH = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [31:0] INSTR_BASE_DEF  = 32'h0000_0400;
   localparam logic [31:0] INSTR_LIMIT_DEF = 32'h0000_0800;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_MERGE_WR,
      S_RESP
   } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction for loads and lane merge for sub-word stores.
// Purely combinational.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] store_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? word[31:16] : word[15:0];

      load_val = word;
      case (size)
         SZ_BYTE: load_val = {{24{is_signed & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_val = {{16{is_signed & half_sel[15]}}, half_sel};
         default: load_val = word;
      endcase

      store_word = word;
      case (size)
         SZ_BYTE: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
         SZ_HALF: begin
            if (lane[1]) store_word[31:16] = wdata[15:0];
            else         store_word[15:0]  = wdata[15:0];
         end
         default: store_word = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator for the single-port unified memory: fetch, load, store with
// read-modify-write for byte/half stores.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter logic [31:0] INSTR_BASE  = INSTR_BASE_DEF,
   parameter logic [31:0] INSTR_LIMIT = INSTR_LIMIT_DEF
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rd
);

   state_t      state, next;
   logic [1:0]  op_q, size_q;
   logic        sgn_q, err_q, illegal;
   logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
   logic [31:0] load_val, store_word;

   mem_lane_align u_align (
      .word       (mem_rd),
      .lane       (addr_q[1:0]),
      .size       (size_q),
      .is_signed  (sgn_q),
      .wdata      (wdata_q),
      .load_val   (load_val),
      .store_word (store_word)
   );

   always_comb begin
      illegal = 1'b0;
      if (req_op == 2'b11 || req_size == 2'b11)
         illegal = 1'b1;
      if (req_op == OP_FETCH &&
          (req_size != SZ_WORD || req_addr[1:0] != 2'b00 ||
           req_addr < INSTR_BASE || req_addr >= INSTR_LIMIT))
         illegal = 1'b1;
      if (req_size == SZ_HALF && req_addr[0])
         illegal = 1'b1;
      if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
         illegal = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next;
   end

   always_comb begin
      next      = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_we    = 1'b0;
      mem_wd    = 32'h0;
      mem_addr  = 32'h0;
      unique case (state)
         S_IDLE: begin
            req_ready = reset_n;
            if (req_valid) next = illegal ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            mem_addr = (op_q == OP_FETCH) ? addr_q : {addr_q[31:2], 2'b00};
            next     = S_RESP;
            if (op_q == OP_STORE) begin
               if (size_q == SZ_WORD) begin
                  mem_we = 1'b1;
                  mem_wd = wdata_q;
               end else begin
                  next = S_MERGE_WR;
               end
            end
         end
         S_MERGE_WR: begin
            mem_addr = {addr_q[31:2], 2'b00};
            mem_we   = 1'b1;
            mem_wd   = merge_q;
            next     = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            next      = S_IDLE;
         end
         default: next = S_IDLE;
      endcase
   end

   // Capture on acceptance; load data and merge word are taken in ACCESS.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         op_q    <= 2'b00;
         size_q  <= 2'b00;
         sgn_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
         merge_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         if (state == S_IDLE && req_valid) begin
            op_q    <= req_op;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= illegal;
         end
         if (state == S_ACCESS) begin
            if (op_q == OP_FETCH)     rdata_q <= mem_rd;
            else if (op_q == OP_LOAD) rdata_q <= load_val;
            else if (size_q != SZ_WORD) merge_q <= store_word;
         end
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a behavioural
// combinational-read memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_addr;
   logic [31:0] mem_rd;

   logic [31:0] mem [0:1023];

   int n_cmp = 0;
   int n_bad = 0;

   int          lat, we_cnt, rdy_hi;
   logic [31:0] r_data, we_addr, we_wd, acc_addr;
   logic        r_err;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_we     (mem_we),
      .mem_wd     (mem_wd),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd)
   );

   assign mem_rd = mem[mem_addr[11:2]];

   always @(posedge clk)
      if (mem_we) mem[mem_addr[11:2]] <= mem_wd;

   task automatic do_req(input logic [1:0] op, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wd);
      int cyc;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL idle_ready got %b want 1", req_ready);
      end
      req_op = op; req_size = sz; req_signed = sgn;
      req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 99; we_cnt = 0; rdy_hi = 0;
      we_addr = 0; we_wd = 0; acc_addr = 0;
      r_data = 0; r_err = 0;
      cyc = 0;
      while (cyc < 8) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) acc_addr = mem_addr;
         if (req_ready) rdy_hi++;
         if (mem_we) begin
            we_cnt++; we_addr = mem_addr; we_wd = mem_wd;
         end
         if (rsp_valid) begin
            lat = cyc; r_data = rsp_rdata; r_err = rsp_err;
            break;
         end
      end
      n_cmp++;
      if (lat == 99) begin
         n_bad++;
         $display("FAIL rsp_timeout got none want rsp_valid within 8");
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({req_ready, rsp_valid, mem_we, rsp_err} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_ctrl got %b want 0000",
                  {req_ready, rsp_valid, mem_we, rsp_err});
      end
      n_cmp++;
      if (rsp_rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_rdata got %h want 0", rsp_rdata);
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_exit_ready got %b want 1", req_ready);
      end
   endtask

   task automatic test_fetch();
      mem[32'h404 >> 2] <= 32'h2003000C;
      do_req(2'b00, 2'b10, 1'b0, 32'h404, 32'h0);
      n_cmp++;
      if (acc_addr !== 32'h404) begin
         n_bad++; $display("FAIL fetch_addr got %h want 404", acc_addr);
      end
      n_cmp++;
      if (lat !== 2) begin
         n_bad++; $display("FAIL fetch_lat got %0d want 2", lat);
      end
      n_cmp++;
      if (r_data !== 32'h2003000C || r_err !== 1'b0) begin
         n_bad++;
         $display("FAIL fetch_data got %h/%b want 2003000c/0", r_data, r_err);
      end
      n_cmp++;
      if (we_cnt !== 0 || rdy_hi !== 0) begin
         n_bad++;
         $display("FAIL fetch_we_rdy got %0d/%0d want 0/0", we_cnt, rdy_hi);
      end
   endtask

   task automatic test_word_store_load();
      do_req(2'b10, 2'b10, 1'b0, 32'h44, 32'hDEADBEEF);
      n_cmp++;
      if (we_cnt !== 1 || we_addr !== 32'h44 || we_wd !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL wstore_we got %0d@%h=%h want 1@44=deadbeef",
                  we_cnt, we_addr, we_wd);
      end
      n_cmp++;
      if (lat !== 2 || r_err !== 1'b0) begin
         n_bad++; $display("FAIL wstore_lat got %0d/%b want 2/0", lat, r_err);
      end
      n_cmp++;
      if (r_data !== 32'h2003000C) begin
         n_bad++; $display("FAIL wstore_hold got %h want 2003000c", r_data);
      end
      do_req(2'b01, 2'b10, 1'b1, 32'h44, 32'h0);
      n_cmp++;
      if (r_data !== 32'hDEADBEEF || lat !== 2 || acc_addr !== 32'h44) begin
         n_bad++;
         $display("FAIL wload got %h lat %0d @%h want deadbeef lat 2 @44",
                  r_data, lat, acc_addr);
      end
   endtask

   task automatic test_subword_store();
      mem[32'h50 >> 2] <= 32'h11223344;
      do_req(2'b10, 2'b00, 1'b0, 32'h51, 32'h123456AA);
      n_cmp++;
      if (we_cnt !== 1 || we_addr !== 32'h50 || we_wd !== 32'h1122AA44) begin
         n_bad++;
         $display("FAIL bstore_we got %0d@%h=%h want 1@50=1122aa44",
                  we_cnt, we_addr, we_wd);
      end
      n_cmp++;
      if (lat !== 3 || r_err !== 1'b0) begin
         n_bad++; $display("FAIL bstore_lat got %0d/%b want 3/0", lat, r_err);
      end
      do_req(2'b10, 2'b01, 1'b0, 32'h52, 32'h0000BEEF);
      n_cmp++;
      if (mem[32'h50 >> 2] !== 32'hBEEFAA44 || we_cnt !== 1 || lat !== 3) begin
         n_bad++;
         $display("FAIL hstore got %h we %0d lat %0d want beefaa44 we 1 lat 3",
                  mem[32'h50 >> 2], we_cnt, lat);
      end
   endtask

   task automatic test_loads();
      logic [1:0]  sz  [7];
      logic        sg  [7];
      logic [31:0] ad  [7];
      logic [31:0] exp [7];
      mem[32'h60 >> 2] <= 32'h0000F080;
      sz[0] = 2'b00; sg[0] = 1; ad[0] = 32'h60; exp[0] = 32'hFFFFFF80;
      sz[1] = 2'b00; sg[1] = 0; ad[1] = 32'h60; exp[1] = 32'h00000080;
      sz[2] = 2'b01; sg[2] = 1; ad[2] = 32'h60; exp[2] = 32'hFFFFF080;
      sz[3] = 2'b01; sg[3] = 0; ad[3] = 32'h60; exp[3] = 32'h0000F080;
      sz[4] = 2'b00; sg[4] = 1; ad[4] = 32'h61; exp[4] = 32'hFFFFFFF0;
      sz[5] = 2'b01; sg[5] = 1; ad[5] = 32'h62; exp[5] = 32'h00000000;
      sz[6] = 2'b10; sg[6] = 1; ad[6] = 32'h60; exp[6] = 32'h0000F080;
      for (int i = 0; i < 7; i++) begin
         do_req(2'b01, sz[i], sg[i], ad[i], 32'h0);
         n_cmp++;
         if (r_data !== exp[i] || r_err !== 1'b0 || we_cnt !== 0) begin
            n_bad++;
            $display("FAIL load_%0d got %h err %b we %0d want %h err 0 we 0",
                     i, r_data, r_err, we_cnt, exp[i]);
         end
      end
   endtask

   task automatic test_errors();
      logic [1:0]  op [7];
      logic [1:0]  sz [7];
      logic [31:0] ad [7];
      op[0] = 2'b01; sz[0] = 2'b10; ad[0] = 32'h46;
      op[1] = 2'b10; sz[1] = 2'b01; ad[1] = 32'h53;
      op[2] = 2'b00; sz[2] = 2'b10; ad[2] = 32'h800;
      op[3] = 2'b11; sz[3] = 2'b10; ad[3] = 32'h40;
      op[4] = 2'b00; sz[4] = 2'b10; ad[4] = 32'h3FC;
      op[5] = 2'b01; sz[5] = 2'b11; ad[5] = 32'h40;
      op[6] = 2'b00; sz[6] = 2'b00; ad[6] = 32'h404;
      for (int i = 0; i < 7; i++) begin
         do_req(op[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF);
         n_cmp++;
         if (lat !== 1 || r_err !== 1'b1 || we_cnt !== 0) begin
            n_bad++;
            $display("FAIL err_%0d got lat %0d err %b we %0d want 1 1 0",
                     i, lat, r_err, we_cnt);
         end
      end
      n_cmp++;
      if (r_data !== 32'h0000F080 || mem[32'h50 >> 2] !== 32'hBEEFAA44) begin
         n_bad++;
         $display("FAIL err_hold got %h/%h want 0000f080/beefaa44",
                  r_data, mem[32'h50 >> 2]);
      end
      @(negedge clk);
      n_cmp++;
      if (rsp_err !== 1'b0) begin
         n_bad++; $display("FAIL err_idle got %b want 0", rsp_err);
      end
   endtask

   task automatic test_mid_reset();
      int bad_we = 0;
      int bad_rsp = 0;
      mem[32'h70 >> 2] <= 32'hCAFEF00D;
      @(negedge clk);
      req_op = 2'b10; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h71; req_wdata = 32'h55; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      if (mem_we) bad_we++;
      if (rsp_valid) bad_rsp++;
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_bad++; $display("FAIL mrst_ready_low got %b want 0", req_ready);
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++; $display("FAIL mrst_ready_high got %b want 1", req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         if (mem_we) bad_we++;
         if (rsp_valid) bad_rsp++;
         @(negedge clk);
      end
      n_cmp++;
      if (bad_we !== 0 || bad_rsp !== 0) begin
         n_bad++;
         $display("FAIL mrst_quiet got we %0d rsp %0d want 0 0", bad_we, bad_rsp);
      end
      n_cmp++;
      if (mem[32'h70 >> 2] !== 32'hCAFEF00D) begin
         n_bad++;
         $display("FAIL mrst_mem got %h want cafef00d", mem[32'h70 >> 2]);
      end
   endtask

   initial begin
      reset_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      test_reset();
      test_fetch();
      test_word_store_load();
      test_subword_store();
      test_loads();
      test_errors();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
